jericalla_sequencer: RTL and testbench
======================================

Name: jericalla_sequencer

Overview:
- Program sequencer for the Jericalla_Evolution datapath.
- Holds a small program memory loaded over a write port.
- On START, issues the stored 17-bit instructions one per cycle to the datapath's instruction input.
- Handles datapath HOLD back-pressure and an optional read-after-write interlock that inserts bubbles; sits between the host/test logic and Jericalla_Evolution.

Parameters:
- INSTR_W, 17: instruction width. Fields: op[16:15], rs1[14:10], rs2[9:5], rd[4:0].
- PROG_DEPTH, 16: program memory entries (power of 2).
- HAZ_GAP, 1: bubble cycles inserted on a RAW hit (legal 1..3).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- LOAD_EN  in  1  write LOAD_DATA into program memory at LOAD_ADDR.
- LOAD_ADDR  in  clog2(PROG_DEPTH)  program memory write address.
- LOAD_DATA  in  INSTR_W  instruction to store.
- START  in  1  begin executing program from address 0.
- LENGTH  in  clog2(PROG_DEPTH)+1  number of instructions to issue; sampled with START.
- HOLD  in  1  datapath stall; freezes issue.
- INSTR_OUT  out  INSTR_W  instruction to datapath; 0 whenever INSTR_VALID=0.
- INSTR_VALID  out  1  INSTR_OUT is a real instruction this cycle.
- PC_OUT  out  clog2(PROG_DEPTH)  address of the instruction currently on INSTR_OUT.
- BUSY  out  1  sequencer is not IDLE.
- DONE  out  1  one-cycle pulse after the last instruction issues.

Behaviour:
- Reset: all outputs 0, state IDLE, PC 0, last_rd/last_valid cleared. Program memory is not reset. Reset asserted mid-run aborts immediately with no DONE pulse.
- All outputs are registered.
- States:
  - IDLE: BUSY=0.
    - START with LENGTH≠0 → RUN; latch len = min(LENGTH, PROG_DEPTH); PC=0.
    - START with LENGTH=0 → DONE.
  - RUN:
    - HOLD=1 → INSTR_VALID=0, PC and state hold.
    - Else, if RAW hit (feature on) → BUBBLE with gap counter = HAZ_GAP, INSTR_VALID=0.
    - Else → issue mem[PC] (INSTR_VALID=1, PC_OUT=PC), record rd, PC++.
    - After issuing index len-1 → DONE.
  - BUBBLE: INSTR_VALID=0; counter decrements each non-HOLD cycle; at 0 → RUN. HOLD freezes the counter. The previous-issue record is cleared on bubble exit, so the same instruction does not re-trigger.
  - DONE: DONE=1 for exactly one cycle, BUSY=1 → IDLE.
- Latency: START sampled at edge N; first INSTR_VALID at edge N+1. With no hazards or HOLD, len instructions issue on edges N+1..N+len and DONE is at N+len+1.
- RAW hit: mem[PC].rs1 == last_rd or mem[PC].rs2 == last_rd, with last_valid=1. Register 0 is not exempt. Only the immediately preceding issued instruction is compared.
- START while BUSY: ignored.
- LOAD_EN while BUSY: write dropped.
- LOAD_EN in IDLE: written at the edge.
- LOAD_EN and START in the same IDLE cycle: the write lands, and the run reads the new contents.
- PC wrap cannot occur, because len ≤ PROG_DEPTH.

Optional Feature:
- Macro JERICALLA_SEQ_HAZARD_EN.
- Defined: RAW interlock and BUBBLE state are active as described.
- Undefined: the hazard compare is removed, BUBBLE is never entered, and HAZ_GAP is unused. Instructions issue back-to-back, gated only by HOLD.

Decomposition:
- Shared package jericalla_pkg:
  - INSTR_W;
  - field LSB/MSB constants for op/rs1/rs2/rd;
  - opcode localparams (2'b00..2'b11);
  - sequencer state enum (IDLE, RUN, BUBBLE, DONE).
- One sub-module, jericalla_hazard_unit: holds last_rd/last_valid, performs the RAW compare, and owns the gap counter. It exists only under JERICALLA_SEQ_HAZARD_EN.

Test Plan:
- Program run, hazard on, HAZ_GAP=1:
  - Stimulus: load 10000110010000000, 01001010000100010, 10001100001000011, 11000000011100100, 11000000100000101, 11000000100100110; START at edge 0 with LENGTH=6.
  - Required: instructions issue on edges 1, 2, 4, 5, 6, 7 (bubble at 3, because instr2 rs2=2 matches instr1 rd=2); DONE at edge 8; PC_OUT sequence 0,1,2,3,4,5.
- Same program, macro undefined: issue on edges 1–6, DONE at 7, no bubble.
- HOLD high at edges 2–3 during the first program: INSTR_VALID=0 there, and no instruction is skipped or duplicated; DONE shifts by 2, to edge 10.
- Corner cases:
  - START with LENGTH=0: DONE pulse at edge 1, no INSTR_VALID.
  - LENGTH=20 with PROG_DEPTH=16: exactly 16 issues.
- RST_N low at edge 3 mid-run: all outputs 0 asynchronously, no DONE. A new START after release runs from PC 0.
- LOAD_EN while BUSY, to address 2: memory unchanged on a later readback run. START asserted during a run is ignored.

Source files
------------

// File: rtl/jericalla_pkg.sv
// rtl/jericalla_pkg.sv - shared constants, field helpers and state type for the Jericalla sequencer
package jericalla_pkg;

   // Instruction word: op[16:15] rs1[14:10] rs2[9:5] rd[4:0]
   localparam int INSTR_W = 17;
   localparam int REG_W   = 5;

   localparam int OP_MSB  = 16;
   localparam int OP_LSB  = 15;
   localparam int RS1_MSB = 14;
   localparam int RS1_LSB = 10;
   localparam int RS2_MSB = 9;
   localparam int RS2_LSB = 5;
   localparam int RD_MSB  = 4;
   localparam int RD_LSB  = 0;

   localparam logic [1:0] OPC_00 = 2'b00;
   localparam logic [1:0] OPC_01 = 2'b01;
   localparam logic [1:0] OPC_10 = 2'b10;
   localparam logic [1:0] OPC_11 = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_BUBBLE = 2'd2,
      ST_DONE   = 2'd3
   } seq_state_t;

   function automatic logic [REG_W-1:0] fld_rs1(input logic [INSTR_W-1:0] ins);
      return ins[RS1_MSB:RS1_LSB];
   endfunction

   function automatic logic [REG_W-1:0] fld_rs2(input logic [INSTR_W-1:0] ins);
      return ins[RS2_MSB:RS2_LSB];
   endfunction

   function automatic logic [REG_W-1:0] fld_rd(input logic [INSTR_W-1:0] ins);
      return ins[RD_MSB:RD_LSB];
   endfunction

endpackage

// File: rtl/jericalla_hazard_unit.sv
// rtl/jericalla_hazard_unit.sv - RAW interlock: last-issue record, compare and bubble gap counter (built only with JERICALLA_SEQ_HAZARD_EN)
`ifdef JERICALLA_SEQ_HAZARD_EN
module jericalla_hazard_unit
   import jericalla_pkg::*;
#(
   parameter int HAZ_GAP = 1
)
(
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [REG_W-1:0] i_rs1,
   input  logic [REG_W-1:0] i_rs2,
   input  logic [REG_W-1:0] i_rd,
   input  logic             i_clear,
   input  logic             i_record,
   input  logic             i_load_gap,
   input  logic             i_step,
   output logic             o_raw_hit,
   output logic             o_gap_done
);

   localparam logic [1:0] GAP_INIT = 2'(HAZ_GAP);

   logic [REG_W-1:0] r_last_rd;
   logic             r_last_valid;
   logic [1:0]       r_gap;

   // A new issue overwrites the record; clear only wins when nothing issues
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_last_rd    <= '0;
         r_last_valid <= 1'b0;
      end else if (i_record) begin
         r_last_rd    <= i_rd;
         r_last_valid <= 1'b1;
      end else if (i_clear) begin
         r_last_valid <= 1'b0;
      end
   end

   // Gap counter: the entry cycle is the first bubble, so exit happens once it reaches 1
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_gap <= '0;
      end else if (i_load_gap) begin
         r_gap <= GAP_INIT;
      end else if (i_step && (r_gap != 2'd0)) begin
         r_gap <= r_gap - 2'd1;
      end
   end

   assign o_raw_hit  = r_last_valid && ((i_rs1 == r_last_rd) || (i_rs2 == r_last_rd));
   assign o_gap_done = (r_gap <= 2'd1);

endmodule
`endif

// File: rtl/jericalla_sequencer.sv
// rtl/jericalla_sequencer.sv - program memory plus issue FSM feeding Jericalla_Evolution; RAW interlock under JERICALLA_SEQ_HAZARD_EN
module jericalla_sequencer
   import jericalla_pkg::*;
#(
   parameter int INSTR_W    = 17,
   parameter int PROG_DEPTH = 16,
   parameter int HAZ_GAP    = 1
)
(
   input  logic                          CLK,
   input  logic                          RST_N,
   input  logic                          LOAD_EN,
   input  logic [$clog2(PROG_DEPTH)-1:0] LOAD_ADDR,
   input  logic [INSTR_W-1:0]            LOAD_DATA,
   input  logic                          START,
   input  logic [$clog2(PROG_DEPTH):0]   LENGTH,
   input  logic                          HOLD,
   output logic [INSTR_W-1:0]            INSTR_OUT,
   output logic                          INSTR_VALID,
   output logic [$clog2(PROG_DEPTH)-1:0] PC_OUT,
   output logic                          BUSY,
   output logic                          DONE
);

   localparam int AW = $clog2(PROG_DEPTH);
   localparam int LW = AW + 1;

   logic [INSTR_W-1:0] r_mem [PROG_DEPTH];

   seq_state_t         r_state;
   seq_state_t         w_state_nxt;
   logic [AW-1:0]      r_pc;
   logic [LW-1:0]      r_len;
   logic [INSTR_W-1:0] r_instr;
   logic               r_valid;
   logic [AW-1:0]      r_pc_out;
   logic               r_busy;
   logic               r_done;

   logic [AW-1:0]      w_pc_nxt;
   logic [LW-1:0]      w_len_nxt;
   logic [INSTR_W-1:0] w_instr_nxt;
   logic               w_valid_nxt;
   logic [AW-1:0]      w_pc_out_nxt;
   logic               w_busy_nxt;
   logic               w_done_nxt;

   logic [INSTR_W-1:0] w_cur;
   logic               w_last;
   logic               w_issue;
   logic               w_load_gap;
   logic               w_step;
   logic               w_haz_clear;
   logic               w_raw_hit;
   logic               w_gap_done;

   assign w_cur  = r_mem[r_pc];
   assign w_last = ({1'b0, r_pc} == (r_len - LW'(1)));

`ifdef JERICALLA_SEQ_HAZARD_EN
   jericalla_hazard_unit #(
      .HAZ_GAP    (HAZ_GAP)
   ) u_hazard (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .i_rs1      (fld_rs1(w_cur)),
      .i_rs2      (fld_rs2(w_cur)),
      .i_rd       (fld_rd(w_cur)),
      .i_clear    (w_haz_clear),
      .i_record   (w_issue),
      .i_load_gap (w_load_gap),
      .i_step     (w_step),
      .o_raw_hit  (w_raw_hit),
      .o_gap_done (w_gap_done)
   );
`else
   // No interlock: never stall on a hazard, bubble exit is immediate (state unreachable)
   logic w_unused_haz;
   assign w_raw_hit    = 1'b0;
   assign w_gap_done   = 1'b1;
   assign w_unused_haz = (HAZ_GAP != 0) ^ w_load_gap ^ w_step ^ w_haz_clear;
`endif

   // Program memory: host writes land only while the sequencer is idle; not reset
   always_ff @(posedge CLK) begin
      if (LOAD_EN && (r_state == ST_IDLE)) begin
         r_mem[LOAD_ADDR] <= LOAD_DATA;
      end
   end

   // Next-state and next-output decode; every registered output is computed here
   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_len_nxt    = r_len;
      w_instr_nxt  = '0;
      w_valid_nxt  = 1'b0;
      w_pc_out_nxt = r_pc_out;
      w_busy_nxt   = 1'b1;
      w_done_nxt   = 1'b0;
      w_issue      = 1'b0;
      w_load_gap   = 1'b0;
      w_step       = 1'b0;
      w_haz_clear  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_busy_nxt = 1'b0;
            if (START) begin
               w_busy_nxt  = 1'b1;
               w_pc_nxt    = '0;
               w_haz_clear = 1'b1;
               if (LENGTH != '0) begin
                  w_len_nxt   = (LENGTH > LW'(PROG_DEPTH)) ? LW'(PROG_DEPTH) : LENGTH;
                  w_state_nxt = ST_RUN;
               end else begin
                  w_state_nxt = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            if (!HOLD) begin
               if (w_raw_hit) begin
                  w_load_gap  = 1'b1;
                  w_state_nxt = ST_BUBBLE;
               end else begin
                  w_issue = 1'b1;
               end
            end
         end
         ST_BUBBLE: begin
            if (!HOLD) begin
               if (w_gap_done) begin
                  // Leaving the bubble issues the stalled instruction directly
                  w_haz_clear = 1'b1;
                  w_issue     = 1'b1;
               end else begin
                  w_step = 1'b1;
               end
            end
         end
         ST_DONE: begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      if (w_issue) begin
         w_valid_nxt  = 1'b1;
         w_instr_nxt  = w_cur;
         w_pc_out_nxt = r_pc;
         w_pc_nxt     = r_pc + AW'(1);
         w_state_nxt  = w_last ? ST_DONE : ST_RUN;
      end
   end

   // FSM state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Program counter, run length and registered outputs
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_pc     <= '0;
         r_len    <= '0;
         r_instr  <= '0;
         r_valid  <= 1'b0;
         r_pc_out <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_pc     <= w_pc_nxt;
         r_len    <= w_len_nxt;
         r_instr  <= w_instr_nxt;
         r_valid  <= w_valid_nxt;
         r_pc_out <= w_pc_out_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
      end
   end

   assign INSTR_OUT   = r_instr;
   assign INSTR_VALID = r_valid;
   assign PC_OUT      = r_pc_out;
   assign BUSY        = r_busy;
   assign DONE        = r_done;

endmodule

// File: tb/tb_jericalla_sequencer.sv
// tb/tb_jericalla_sequencer.sv - scoreboard bench for jericalla_sequencer with hand-computed issue/DONE timing
module tb_jericalla_sequencer;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          LOAD_EN = 1'b0;
   logic [AW-1:0] LOAD_ADDR = '0;
   logic [16:0]   LOAD_DATA = '0;
   logic          START = 1'b0;
   logic [AW:0]   LENGTH = '0;
   logic          HOLD = 1'b0;
   logic [16:0]   INSTR_OUT;
   logic          INSTR_VALID;
   logic [AW-1:0] PC_OUT;
   logic          BUSY;
   logic          DONE;

   jericalla_sequencer #(
      .INSTR_W     (17),
      .PROG_DEPTH  (DEPTH),
      .HAZ_GAP     (1)
   ) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .LOAD_EN     (LOAD_EN),
      .LOAD_ADDR   (LOAD_ADDR),
      .LOAD_DATA   (LOAD_DATA),
      .START       (START),
      .LENGTH      (LENGTH),
      .HOLD        (HOLD),
      .INSTR_OUT   (INSTR_OUT),
      .INSTR_VALID (INSTR_VALID),
      .PC_OUT      (PC_OUT),
      .BUSY        (BUSY),
      .DONE        (DONE)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int          at;
      int          pc;
      logic [16:0] ins;
   } exp_t;

   exp_t        exp_q[$];
   int          done_q[$];
   logic [16:0] prog [DEPTH];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          t0 = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   // Monitor: pops expected issues/DONE pulses as the DUT presents them
   always @(negedge CLK) begin
      if (RST_N) begin
         if (INSTR_VALID) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_issue edge=%0d pc=%0d ins=%h required no issue", cyc - t0, PC_OUT, INSTR_OUT);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if ((cyc - t0) != e.at || int'(PC_OUT) != e.pc || INSTR_OUT !== e.ins) begin
                  errors++;
                  $display("FAIL issue got edge=%0d pc=%0d ins=%h required edge=%0d pc=%0d ins=%h",
                           cyc - t0, PC_OUT, INSTR_OUT, e.at, e.pc, e.ins);
               end
            end
         end else begin
            checks++;
            if (INSTR_OUT !== 17'd0) begin
               errors++;
               $display("FAIL instr_zero_when_invalid got %h required 0", INSTR_OUT);
            end
         end
         if (DONE) begin
            checks++;
            if (done_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done edge=%0d required no DONE", cyc - t0);
            end else begin
               int d;
               d = done_q.pop_front();
               if ((cyc - t0) != d) begin
                  errors++;
                  $display("FAIL done_edge got %0d required %0d", cyc - t0, d);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d required %0d", name, got, want);
      end
   endtask

   task automatic load(input int addr, input logic [16:0] data);
      LOAD_EN   = 1'b1;
      LOAD_ADDR = AW'(addr);
      LOAD_DATA = data;
      tick();
      LOAD_EN   = 1'b0;
      prog[addr] = data;
   endtask

   // START sampled at the edge this task waits on; that edge becomes edge 0
   task automatic start_run(input int len);
      START  = 1'b1;
      LENGTH = (AW+1)'(len);
      tick();
      START  = 1'b0;
      t0     = cyc;
   endtask

   task automatic push_issue(input int at, input int pc);
      exp_t e;
      e.at  = at;
      e.pc  = pc;
      e.ins = prog[pc];
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || done_q.size() != 0 || BUSY) && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 200) begin
         errors++;
         $display("FAIL %s_timeout got pending issues=%0d dones=%0d busy=%0d required 0/0/0",
                  name, exp_q.size(), done_q.size(), BUSY);
         exp_q.delete();
         done_q.delete();
      end
      check({name, "_done_low"}, int'(DONE), 0);
   endtask

   task automatic check_outputs_zero(input string name);
      check({name, "_instr"}, int'(INSTR_OUT), 0);
      check({name, "_valid"}, int'(INSTR_VALID), 0);
      check({name, "_pc"},    int'(PC_OUT), 0);
      check({name, "_busy"},  int'(BUSY), 0);
      check({name, "_done"},  int'(DONE), 0);
   endtask

   initial begin
      logic [16:0] p6 [6];
      int          e_plain [6];
      int          e_hold  [6];
      int          d_plain;
      int          d_hold;

      p6[0] = 17'b10000110010000000;
      p6[1] = 17'b01001010000100010;
      p6[2] = 17'b10001100001000011;
      p6[3] = 17'b11000000011100100;
      p6[4] = 17'b11000000100000101;
      p6[5] = 17'b11000000100100110;

`ifdef JERICALLA_SEQ_HAZARD_EN
      e_plain = '{1, 2, 4, 5, 6, 7};
      d_plain = 8;
      e_hold  = '{1, 4, 6, 7, 8, 9};
      d_hold  = 10;
`else
      e_plain = '{1, 2, 3, 4, 5, 6};
      d_plain = 7;
      e_hold  = '{1, 4, 5, 6, 7, 8};
      d_hold  = 9;
`endif

      // Reset state
      repeat (3) tick();
      check_outputs_zero("reset");
      RST_N = 1'b1;
      tick();

      // Six-instruction program, no stalls
      for (int i = 0; i < 6; i++) load(i, p6[i]);
      start_run(6);
      for (int i = 0; i < 6; i++) push_issue(e_plain[i], i);
      done_q.push_back(d_plain);
      wait_drain("prog6");

      // Same program with HOLD sampled high at edges 2 and 3
      start_run(6);
      for (int i = 0; i < 6; i++) push_issue(e_hold[i], i);
      done_q.push_back(d_hold);
      tick();
      HOLD = 1'b1;
      tick();
      tick();
      HOLD = 1'b0;
      wait_drain("hold");

      // Zero length: DONE at edge 1, nothing issued
      start_run(0);
      done_q.push_back(1);
      wait_drain("len0");

      // Full memory of hazard-free words, LENGTH clamped from 20 to 16
      for (int k = 0; k < DEPTH; k++) begin
         logic [4:0] kk;
         kk = 5'(k);
         load(k, {kk[1:0], 5'd31, 5'd31, kk});
      end
      start_run(20);
      for (int k = 0; k < DEPTH; k++) push_issue(k + 1, k);
      done_q.push_back(DEPTH + 1);
      repeat (4) tick();
      // Write and START while busy must both be ignored
      LOAD_EN   = 1'b1;
      LOAD_ADDR = AW'(2);
      LOAD_DATA = 17'h1ABCD;
      START     = 1'b1;
      LENGTH    = 5'd3;
      tick();
      LOAD_EN   = 1'b0;
      START     = 1'b0;
      wait_drain("len20");

      // Readback: address 2 still holds the original word
      start_run(3);
      for (int k = 0; k < 3; k++) push_issue(k + 1, k);
      done_q.push_back(4);
      wait_drain("readback");

      // Load and START in the same idle cycle: the run sees the new word
      LOAD_EN   = 1'b1;
      LOAD_ADDR = AW'(0);
      LOAD_DATA = 17'h0F0F3;
      prog[0]   = 17'h0F0F3;
      start_run(1);
      LOAD_EN   = 1'b0;
      push_issue(1, 0);
      done_q.push_back(2);
      wait_drain("load_start");

      // Reset mid-run after two issues: outputs clear at once, no DONE
      start_run(6);
      push_issue(1, 0);
      push_issue(2, 1);
      tick();
      tick();
      #5;
      RST_N = 1'b0;
      #1;
      check_outputs_zero("midreset");
      repeat (2) tick();
      RST_N = 1'b1;
      repeat (4) tick();
      check("midreset_pending", exp_q.size(), 0);
      check("midreset_busy", int'(BUSY), 0);

      // Fresh run after reset starts at PC 0
      start_run(2);
      push_issue(1, 0);
      push_issue(2, 1);
      done_q.push_back(3);
      wait_drain("rerun");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule
